spike_rate_encoder: RTL

// - Drives the bitline accumulator: turns COLS per-channel magnitudes into rate-coded spike trains.
// - Each input vector runs one integration window: a one-cycle acc_clear, then WINDOW_LEN spike cycles.
// - Sits upstream of the accumulator; spikes_out drives its spikes_in, acc_clear drives its clear.

---
 rtl/spike_enc_pkg.sv | 31 +++
 rtl/spike_phase_lane.sv | 70 +++++++
 rtl/spike_rate_encoder.sv | 111 +++++++++++
 3 files changed

// File: rtl/spike_enc_pkg.sv
// spike_enc_pkg: shared FSM state encoding and LFSR constants for the
// spike-rate encoder (stochastic mode is built with SPIKE_LFSR_EN).
package spike_enc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LFSR_W = 16;

  // Galois right-shift mask for taps 16,14,13,11
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    lfsr_next = (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  // r must be in 0..LFSR_W-1; a shift by LFSR_W yields 0
  function automatic logic [LFSR_W-1:0] rotl(
    input logic [LFSR_W-1:0] s,
    input int unsigned       r
  );
    rotl = (s << r) | (s >> (LFSR_W - r));
  endfunction

endpackage

// File: rtl/spike_phase_lane.sv
// spike_phase_lane: one channel's magnitude, phase and registered spike.
// Ports: clk, rst_n, load_i/mag_i (latch), step_i (run cycle), [rnd_i], spike_o.
module spike_phase_lane
  import spike_enc_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] mag_i,
  input  logic                  step_i,
`ifdef SPIKE_LFSR_EN
  input  logic [DATA_WIDTH-1:0] rnd_i,
`endif
  output logic                  spike_o
);

  logic [DATA_WIDTH-1:0] mag_q;
  logic                  spike_q;
  logic                  spike_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= '0;
    end else if (load_i) begin
      mag_q <= mag_i;
    end
  end

`ifdef SPIKE_LFSR_EN
  assign spike_d = step_i && (mag_q > rnd_i);
`else
  logic [DATA_WIDTH-1:0] phase_q;
  logic [DATA_WIDTH-1:0] phase_d;
  logic [DATA_WIDTH:0]   sum;

  // carry-out of the phase add is the spike for this cycle
  assign sum = {1'b0, phase_q} + {1'b0, mag_q};
  assign spike_d = step_i && sum[DATA_WIDTH];

  always_comb begin
    phase_d = phase_q;
    if (load_i) begin
      phase_d = '0;
    end else if (step_i) begin
      phase_d = sum[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike_d;
    end
  end

  assign spike_o = spike_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: rate-codes COLS magnitudes into spike trains, one window per vector.
// Ports: in_valid/in_ready/in_data, abort, spikes_out, acc_clear, window_active/done; SPIKE_LFSR_EN = stochastic.
module spike_rate_encoder
  import spike_enc_pkg::*;
#(
  parameter int              DATA_WIDTH = 8,
  parameter int              COLS       = 32,
  parameter int              WINDOW_LEN = 256,
  parameter logic [15:0]     LFSR_SEED  = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [COLS*DATA_WIDTH-1:0] in_data,
  input  logic                       abort,
  output logic [COLS-1:0]            spikes_out,
  output logic                       acc_clear,
  output logic                       window_active,
  output logic                       window_done
);

  localparam int CW = $clog2(WINDOW_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(WINDOW_LEN - 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept;
  logic          step;

  assign in_ready = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !abort;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = accept ? ST_CLEAR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // lanes compute the spike for the RUN cycle being entered
  assign step = (state_d == ST_RUN);

  assign acc_clear     = (state_q == ST_CLEAR);
  assign window_active = (state_q == ST_RUN);
  assign window_done   = (state_q == ST_DONE);

`ifdef SPIKE_LFSR_EN
  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end
`endif

  for (genvar i = 0; i < COLS; i++) begin : g_lane
`ifdef SPIKE_LFSR_EN
    logic [DATA_WIDTH-1:0] rnd;
    assign rnd = DATA_WIDTH'(rotl(lfsr_q, i % LFSR_W));
`endif
    spike_phase_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (accept),
      .mag_i  (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .step_i (step),
`ifdef SPIKE_LFSR_EN
      .rnd_i  (rnd),
`endif
      .spike_o(spikes_out[i])
    );
  end

endmodule
